// File: rtl/bus_master_seq_pkg.sv
// Shared encodings for the bus initiator: transfer sizes, sequencer states, default timeout.
// Also holds helpers for request validation and first-cycle write-lane formatting.
package bus_master_seq_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_WORD = 2'd1;
    localparam logic [1:0] SZ_LONG = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CYC1,
        ST_GAP,
        ST_CYC2,
        ST_RESP
    } state_t;

    // Misaligned word/long or reserved size never reaches the bus.
    function automatic logic bad_request(input logic [1:0] size, input logic addr0);
        return (size == SZ_RSVD) || ((size != SZ_BYTE) && addr0);
    endfunction

    // Byte data is mirrored onto both lanes; a long starts with its upper word.
    function automatic logic [15:0] first_word(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {wdata[7:0], wdata[7:0]};
            SZ_WORD: return wdata[15:0];
            default: return wdata[31:16];
        endcase
    endfunction

endpackage

// File: rtl/bus_master_seq_timeout.sv
// Strobe-high cycle counter for the ack timeout; expired is high on the last allowed cycle.
// Only instantiated when BUS_MASTER_TIMEOUT_EN is defined.
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TO_W-1:0] count_reg;

    assign expired = (count_reg == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/bus_master_seq.sv
// Bus initiator for the 16-bit big-endian system bus; longs run as two word cycles.
// Optional ack timeout enabled by defining BUS_MASTER_TIMEOUT_EN.
module bus_master_seq
    import bus_master_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_rw,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] bus_addr,
    output logic [15:0] bus_write,
    input  logic [15:0] bus_read,
    output logic        bus_uds,
    output logic        bus_lds,
    output logic        bus_rw,
    input  logic        bus_ack
);

    state_t      state_reg;
    logic [1:0]  size_reg;
    logic        addr0_reg;
    logic [15:0] wdata_lo_reg;
    logic        timeout_expired;

    // Parameter sanity guard; illegal settings elaborate an empty marker block.
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535 || TO_W < 1) begin : g_illegal_timeout_cfg
    end

`ifdef BUS_MASTER_TIMEOUT_EN
    logic in_cycle;
    assign in_cycle = (state_reg == ST_CYC1) || (state_reg == ST_CYC2);

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_cycle),
        .enable (in_cycle),
        .expired(timeout_expired)
    );
`else
    assign timeout_expired = 1'b0;
`endif

    assign req_ready = (state_reg == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            size_reg     <= SZ_BYTE;
            addr0_reg    <= 1'b0;
            wdata_lo_reg <= '0;
            rsp_valid    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata    <= '0;
            bus_addr     <= '0;
            bus_write    <= '0;
            bus_uds      <= 1'b0;
            bus_lds      <= 1'b0;
            bus_rw       <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        size_reg     <= req_size;
                        addr0_reg    <= req_addr[0];
                        wdata_lo_reg <= req_wdata[15:0];
                        rsp_rdata    <= '0;
                        if (bad_request(req_size, req_addr[0])) begin
                            state_reg <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state_reg <= ST_CYC1;
                            bus_addr  <= req_addr;
                            bus_rw    <= req_rw;
                            bus_write <= first_word(req_size, req_wdata);
                            bus_uds   <= !((req_size == SZ_BYTE) && req_addr[0]);
                            bus_lds   <= !((req_size == SZ_BYTE) && !req_addr[0]);
                        end
                    end
                end
                ST_CYC1, ST_CYC2: begin
                    if (bus_ack) begin
                        bus_uds <= 1'b0;
                        bus_lds <= 1'b0;
                        if (bus_rw) begin
                            case (size_reg)
                                SZ_BYTE: rsp_rdata <= {24'd0, addr0_reg ? bus_read[7:0] : bus_read[15:8]};
                                SZ_WORD: rsp_rdata <= {16'd0, bus_read};
                                default: begin
                                    if (state_reg == ST_CYC1) rsp_rdata[31:16] <= bus_read;
                                    else                      rsp_rdata[15:0]  <= bus_read;
                                end
                            endcase
                        end
                        if (state_reg == ST_CYC1 && size_reg == SZ_LONG) begin
                            state_reg <= ST_GAP;
                            bus_addr  <= bus_addr + 32'd2;
                            bus_write <= wdata_lo_reg;
                        end else begin
                            state_reg <= ST_RESP;
                            rsp_valid <= 1'b1;
                        end
                    end else if (timeout_expired) begin
                        bus_uds   <= 1'b0;
                        bus_lds   <= 1'b0;
                        state_reg <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                ST_GAP: begin
                    state_reg <= ST_CYC2;
                    bus_uds   <= 1'b1;
                    bus_lds   <= 1'b1;
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_seq.sv
// Randomized self-checking bench for bus_master_seq with an in-bench slave and transaction model.
// Timeout scenarios are exercised only when BUS_MASTER_TIMEOUT_EN is defined.
module tb_bus_master_seq;

    localparam int TO     = 8;
    localparam int BUDGET = 200;
    localparam int NEVER  = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_rw = 1'b1;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] bus_addr;
    logic [15:0] bus_write;
    logic [15:0] bus_read = '0;
    logic        bus_uds;
    logic        bus_lds;
    logic        bus_rw;
    logic        bus_ack = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    always #5 clk = ~clk;

    bus_master_seq #(
        .TIMEOUT_CYCLES(TO),
        .TO_W          (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_size (req_size),
        .req_rw   (req_rw),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .bus_addr (bus_addr),
        .bus_write(bus_write),
        .bus_read (bus_read),
        .bus_uds  (bus_uds),
        .bus_lds  (bus_lds),
        .bus_rw   (bus_rw),
        .bus_ack  (bus_ack)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One client transaction; w0/w1 are wait states before ack on each bus cycle.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                           input logic rw, input int w0, input int w1,
                           input logic [15:0] d0, input logic [15:0] d1);
        bit          bad;
        bit          to_hit;
        bit          got_rsp;
        int          ncyc;
        int          waits [2];
        int          hi_len [2];
        logic [15:0] rd [2];
        logic [31:0] exp_addr [2];
        logic [15:0] exp_wr [2];
        logic        exp_uds;
        logic        exp_lds;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          cyc_idx;
        int          hi_cnt;
        int          idx;

        // Reference model: derive expected bus cycles and response from the request alone.
        bad       = (sz == 2'd3) || (sz != 2'd0 && a[0]);
        ncyc      = bad ? 0 : ((sz == 2'd2) ? 2 : 1);
        waits[0]  = w0;
        waits[1]  = w1;
        rd[0]     = d0;
        rd[1]     = d1;
        hi_len[0] = w0 + 1;
        hi_len[1] = w1 + 1;
        to_hit    = 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
        for (int i = 0; i < ncyc; i++) begin
            if (!to_hit && waits[i] + 1 > TO) begin
                hi_len[i] = TO;
                to_hit    = 1'b1;
                ncyc      = i + 1;
            end
        end
`endif
        exp_addr[0] = a;
        exp_addr[1] = a + 32'd2;
        if (sz == 2'd0) begin
            exp_wr[0] = {wd[7:0], wd[7:0]};
            exp_uds   = !a[0];
            exp_lds   = a[0];
        end else begin
            exp_wr[0] = (sz == 2'd2) ? wd[31:16] : wd[15:0];
            exp_uds   = 1'b1;
            exp_lds   = 1'b1;
        end
        exp_wr[1] = wd[15:0];
        exp_err   = bad || to_hit;
        exp_rdata = 32'd0;
        if (rw && !exp_err) begin
            if (sz == 2'd0)      exp_rdata = a[0] ? {24'd0, d0[7:0]} : {24'd0, d0[15:8]};
            else if (sz == 2'd1) exp_rdata = {16'd0, d0};
            else                 exp_rdata = {d0, d1};
        end
        exp_lat = 1;
        for (int i = 0; i < ncyc; i++) exp_lat += hi_len[i];
        if (ncyc > 1) exp_lat += ncyc - 1;

        @(negedge clk);
        check("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_wdata = wd;
        req_size  = sz;
        req_rw    = rw;
        @(negedge clk);
        req_valid = 1'b0;

        cyc_idx = 0;
        hi_cnt  = 0;
        got_rsp = 1'b0;
        for (int t = 1; t <= BUDGET; t++) begin
            if (!(bus_uds || bus_lds) && hi_cnt > 0) begin
                idx = (cyc_idx > 1) ? 1 : cyc_idx;
                check("strobe_len", hi_cnt, hi_len[idx]);
                cyc_idx++;
                hi_cnt = 0;
            end
            if (rsp_valid) begin
                bus_ack = 1'b0;
                check("latency", t, exp_lat);
                check("bus_cycles", cyc_idx, ncyc);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
                check("rsp_rdata", rsp_rdata, exp_rdata);
                got_rsp = 1'b1;
                break;
            end
            check("ready_busy", {31'd0, req_ready}, 32'd0);
            if (bus_uds || bus_lds) begin
                check("cycle_in_range", {31'd0, cyc_idx < ncyc}, 32'd1);
                idx = (cyc_idx > 1) ? 1 : cyc_idx;
                check("bus_addr", bus_addr, exp_addr[idx]);
                check("strobes", {30'd0, bus_uds, bus_lds}, {30'd0, exp_uds, exp_lds});
                check("bus_rw", {31'd0, bus_rw}, {31'd0, rw});
                if (!rw) check("bus_write", {16'd0, bus_write}, {16'd0, exp_wr[idx]});
                hi_cnt++;
                bus_ack  = (hi_cnt == waits[idx] + 1);
                bus_read = bus_ack ? rd[idx] : 16'($urandom);
            end else begin
                bus_ack  = 1'b0;
                bus_read = 16'($urandom);
            end
            @(negedge clk);
        end
        bus_ack = 1'b0;
        check("rsp_seen", {31'd0, got_rsp}, 32'd1);
        @(negedge clk);
        check("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
        n_txn++;
        $display("txn %0d: addr=%08h size=%0d rw=%0d waits=%0d/%0d err=%0b rdata=%08h",
                 n_txn, a, sz, rw, w0, w1, rsp_err, rsp_rdata);
    endtask

    task automatic reset_in_cyc2();
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0010_0400;
        req_size  = 2'd2;
        req_rw    = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        bus_ack   = 1'b1;
        bus_read  = 16'hDEAD;
        @(negedge clk);
        bus_ack = 1'b0;
        check("rst_gap_low", {30'd0, bus_uds, bus_lds}, 32'd0);
        @(negedge clk);
        check("rst_cyc2_high", {30'd0, bus_uds, bus_lds}, 32'd3);
        check("rst_cyc2_addr", bus_addr, 32'h0010_0402);
        reset = 1'b1;
        @(negedge clk);
        check("rst_strobes", {30'd0, bus_uds, bus_lds}, 32'd0);
        check("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_no_rsp_after", {31'd0, rsp_valid}, 32'd0);
        $display("txn reset-in-cyc2: strobes=%0b%0b ready=%0b", bus_uds, bus_lds, req_ready);
    endtask

    initial begin
        int sel;
        logic [31:0] ra;
        repeat (3) @(negedge clk);
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        check("reset_strobes", {30'd0, bus_uds, bus_lds}, 32'd0);
        check("reset_addr", bus_addr, 32'd0);
        check("reset_write", {16'd0, bus_write}, 32'd0);
        check("reset_rw", {31'd0, bus_rw}, 32'd1);
        reset = 1'b0;

        run_txn(32'h0000_0100, 32'h0000_1234, 2'd1, 1'b0, 0, 0, 16'h0, 16'h0);
        run_txn(32'h0010_0400, 32'h0, 2'd2, 1'b1, 2, 2, 16'hDEAD, 16'hBEEF);
        run_txn(32'h0000_0003, 32'h0, 2'd0, 1'b1, 0, 0, 16'h55AA, 16'h0);
        run_txn(32'h0000_0002, 32'h0, 2'd0, 1'b1, 0, 0, 16'h55AA, 16'h0);
        run_txn(32'h0000_0101, 32'hCAFE_F00D, 2'd1, 1'b0, 0, 0, 16'h0, 16'h0);
        run_txn(32'h0000_0200, 32'h0, 2'd3, 1'b1, 0, 0, 16'h0, 16'h0);
        run_txn(32'hFFFF_FFFE, 32'h1122_3344, 2'd2, 1'b0, 0, 0, 16'h0, 16'h0);
        run_txn(32'h0000_0011, 32'h0000_00A5, 2'd0, 1'b0, 1, 0, 16'h0, 16'h0);
        run_txn(32'h0000_0010, 32'h0000_003C, 2'd0, 1'b0, 0, 0, 16'h0, 16'h0);
`ifdef BUS_MASTER_TIMEOUT_EN
        run_txn(32'h0020_0000, 32'h0, 2'd1, 1'b1, NEVER, 0, 16'h1111, 16'h0);
        run_txn(32'h0020_0000, 32'h0, 2'd1, 1'b1, TO - 1, 0, 16'h2222, 16'h0);
        run_txn(32'h0020_0000, 32'h0, 2'd2, 1'b1, NEVER, 0, 16'h3333, 16'h4444);
        run_txn(32'h0020_0000, 32'h0, 2'd2, 1'b1, 1, NEVER, 16'h3333, 16'h4444);
`endif
        reset_in_cyc2();

        for (int n = 0; n < 60; n++) begin
            int rw0;
            int rw1;
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra[0] = 1'b0;
            rw0 = $urandom_range(0, 3);
            rw1 = $urandom_range(0, 3);
`ifdef BUS_MASTER_TIMEOUT_EN
            sel = $urandom_range(0, 7);
            if (sel == 6) rw0 = TO - 1;
            if (sel == 7) rw1 = TO + 3;
`else
            sel = 0;
`endif
            run_txn(ra, $urandom, 2'($urandom_range(0, 3)), 1'($urandom), rw0, rw1,
                    16'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
